ins_mem_arbiter: RTL and testbench
==================================

Name: ins_mem_arbiter

Overview:
- Shares one block-based instruction memory between NUM_REQ per-core instruction-cache refill ports.
- The memory is single-ported: 28-bit block address, 128-bit block, READ/BUSYWAIT handshake.
- Round-robin arbitration; exactly one memory read in flight at a time.
- Sits between the core I-cache controllers and the instruction memory inside the multi-core tile.

Parameters:
- NUM_REQ, 4, number of requesting I-cache ports (2..8).
- TIMEOUT_CYCLES, 1023, watchdog limit in WAIT; used only when ARB_TIMEOUT_EN is defined.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RESET  input  1  synchronous, active-high reset.
- REQ_READ  input  NUM_REQ  per-requester block read request; level, held until served.
- REQ_ADDRESS  input  NUM_REQ*28  packed block addresses; requester i uses bits [28i+27:28i].
- REQ_READDATA  output  NUM_REQ*128  packed returned blocks; slice i valid when requester i is served.
- REQ_BUSYWAIT  output  NUM_REQ  per-requester stall.
- MEM_READ  output  1  read strobe to the instruction memory.
- MEM_ADDRESS  output  28  block address to the memory.
- MEM_READDATA  input  128  block from the memory.
- MEM_BUSYWAIT  input  1  memory busy.
- ERROR  output  NUM_REQ  per-requester timeout flag.

Behaviour:
- Interface (decided): one clock CLK; RESET is synchronous and active-high.
- Reset values: state IDLE, MEM_READ=0, MEM_ADDRESS=0, REQ_READDATA all 0, DONE vector 0, ERROR 0, rr pointer = NUM_REQ-1, so requester 0 wins first.
- REQ_BUSYWAIT[i] = REQ_READ[i] & ~done[i]. This is combinational; done is a registered one-hot.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any REQ_READ is set, pick the first set bit searching from rr+1 with wrap-around.
  - Latch grant index g and MEM_ADDRESS = REQ_ADDRESS[g].
  - Set MEM_READ=1 and go to ISSUE.
  - With no request, stay in IDLE.
- ISSUE: hold MEM_READ and MEM_ADDRESS for exactly one cycle, then go to WAIT. MEM_BUSYWAIT is ignored in this cycle so the memory can respond.
- WAIT: hold MEM_READ=1 and the address. When MEM_BUSYWAIT is sampled 0:
  - latch MEM_READDATA into slice g;
  - drop MEM_READ;
  - set done[g]=1, rr=g;
  - go to DONE.
- DONE: lasts one cycle, in which REQ_BUSYWAIT[g] is low and slice g is valid. Then clear done and return to IDLE.
- Latency:
  - A request sampled at posedge k makes MEM_READ high after posedge k.
  - With a memory that completes in M cycles after the ISSUE posedge, REQ_BUSYWAIT drops after posedge k+M+2.
  - Back-to-back service has one IDLE arbitration cycle between grants.
- REQ_READDATA slices hold their last value until overwritten by the next service of that requester.
- Address change while waiting: MEM_ADDRESS is latched, so a later change to REQ_ADDRESS[g] does not affect the in-flight read.
- Requester drops REQ_READ mid-transaction: the read still completes, data is written to slice g, rr advances, and done is set. REQ_BUSYWAIT[g] stays 0 because READ is 0.
- Requester holds REQ_READ through DONE: this is a new request and re-enters arbitration in the next IDLE, at lowest priority.
- Simultaneous requests: round-robin. With all requesters active, grant order is 0,1,2,…,NUM_REQ-1,0.
- RESET asserted in ISSUE/WAIT: next state IDLE with MEM_READ=0; no data written; the in-flight read is abandoned.

Optional Feature:
- Macro name: ARB_TIMEOUT_EN.
- When defined:
  - A cycle counter runs in WAIT.
  - If it reaches TIMEOUT_CYCLES with MEM_BUSYWAIT still 1: drop MEM_READ, write 128'h0 to slice g, set done[g] and ERROR[g], rr=g, go to DONE.
  - ERROR[g] is sticky until RESET.
- When not defined: no counter; WAIT is unbounded; ERROR is tied to 0.

Test Plan:
- Single request, requester 2, address 28'h0000003, memory returns block 128'hA5…A5 after 5 cycles -> MEM_ADDRESS=3; REQ_BUSYWAIT[2] falls after posedge k+7 for one cycle; slice 2=A5…A5; other slices 0.
- All 4 requesters assert at once with addresses 0,1,2,3 -> served in order 0,1,2,3; each slice i = block i; exactly one MEM_READ pulse per grant, with at least one idle cycle between them.
- Requester 1 keeps REQ_READ high while 0 and 3 request -> sequence 0,1,3,0,1,3 (requester 1 is never served twice in a row while others wait).
- Requester 0 drops REQ_READ during WAIT -> read completes, slice 0 updated, next grant goes to the next pending requester, REQ_BUSYWAIT[0] stays 0.
- RESET pulsed during WAIT -> MEM_READ=0 the next cycle, state IDLE, all slices 0, rr reset, so a pending requester 0 is granted first.
- ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, memory busy forever -> MEM_READ drops after 8 WAIT cycles; slice g=0; ERROR[g]=1 and remains 1 until RESET.

Source files
------------

// File: rtl/ins_mem_arbiter_if.sv
// rtl/ins_mem_arbiter_if.sv - refill-port and instruction-memory bus bundle for ins_mem_arbiter
// master is the arbiter's view; slave is the requester/memory environment's view.
interface ins_mem_arbiter_if #(
    parameter int NUM_REQ = 4
);
    logic [NUM_REQ-1:0]     REQ_READ;
    logic [NUM_REQ*28-1:0]  REQ_ADDRESS;
    logic [NUM_REQ*128-1:0] REQ_READDATA;
    logic [NUM_REQ-1:0]     REQ_BUSYWAIT;
    logic                   MEM_READ;
    logic [27:0]            MEM_ADDRESS;
    logic [127:0]           MEM_READDATA;
    logic                   MEM_BUSYWAIT;
    logic [NUM_REQ-1:0]     ERROR;

    modport master (
        input  REQ_READ, REQ_ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        output REQ_READDATA, REQ_BUSYWAIT, MEM_READ, MEM_ADDRESS, ERROR
    );

    modport slave (
        output REQ_READ, REQ_ADDRESS, MEM_READDATA, MEM_BUSYWAIT,
        input  REQ_READDATA, REQ_BUSYWAIT, MEM_READ, MEM_ADDRESS, ERROR
    );
endinterface

// File: rtl/ins_mem_arbiter.sv
// rtl/ins_mem_arbiter.sv - round-robin sharing of one block instruction memory among I-cache refill ports
// Optional WAIT watchdog with sticky per-requester ERROR is enabled by defining ARB_TIMEOUT_EN.
module ins_mem_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic              CLK,
    input  logic              RESET,
    ins_mem_arbiter_if.master bus
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                 state, state_next;
    logic [IW-1:0]          rr, grant, pick, cand;
    logic                   pick_valid;
    logic                   complete, timeout;
    logic                   mem_read;
    logic [27:0]            mem_address;
    logic [NUM_REQ*128-1:0] readdata;
    logic [NUM_REQ-1:0]     done, error;

    // Scan from the farthest candidate back to rr+1 so the nearest one after rr wins.
    always_comb begin
        pick       = rr;
        pick_valid = 1'b0;
        cand       = '0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            cand = IW'((int'(rr) + off) % NUM_REQ);
            if (bus.REQ_READ[cand]) begin
                pick       = cand;
                pick_valid = 1'b1;
            end
        end
    end

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] wait_cnt;

    always_ff @(posedge CLK) begin
        if (RESET || state != WAIT) wait_cnt <= '0;
        else                        wait_cnt <= wait_cnt + 1'b1;
    end

    assign timeout = (state == WAIT) && bus.MEM_BUSYWAIT && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
    assign timeout            = 1'b0;
`endif

    assign complete = (state == WAIT) && !bus.MEM_BUSYWAIT;

    always_ff @(posedge CLK) begin
        if (RESET) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (pick_valid) state_next = ISSUE;
            ISSUE:   state_next = WAIT;
            WAIT:    if (complete || timeout) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            rr          <= IW'(NUM_REQ - 1);
            grant       <= '0;
            mem_read    <= 1'b0;
            mem_address <= '0;
            readdata    <= '0;
            done        <= '0;
            error       <= '0;
        end else begin
            case (state)
                IDLE: if (pick_valid) begin
                    grant       <= pick;
                    mem_address <= bus.REQ_ADDRESS[int'(pick)*28 +: 28];
                    mem_read    <= 1'b1;
                end
                WAIT: if (complete || timeout) begin
                    mem_read    <= 1'b0;
                    readdata[int'(grant)*128 +: 128] <= timeout ? 128'h0 : bus.MEM_READDATA;
                    done[grant] <= 1'b1;
                    rr          <= grant;
                    if (timeout) error[grant] <= 1'b1;
                end
                DONE: done <= '0;
                default: ;
            endcase
        end
    end

    assign bus.MEM_READ     = mem_read;
    assign bus.MEM_ADDRESS  = mem_address;
    assign bus.REQ_READDATA = readdata;
    assign bus.REQ_BUSYWAIT = bus.REQ_READ & ~done;
    assign bus.ERROR        = error;
endmodule

// File: tb/tb_ins_mem_arbiter.sv
// tb/tb_ins_mem_arbiter.sv - self-checking bench for ins_mem_arbiter with transaction-level reference model
// Watchdog steps are included when ARB_TIMEOUT_EN is defined.
module tb_ins_mem_arbiter;
    localparam int N   = 4;
    localparam int TMO = 8;

    logic clk = 1'b0;
    logic rst;

    ins_mem_arbiter_if #(.NUM_REQ(N)) bus ();

    ins_mem_arbiter #(.NUM_REQ(N), .TIMEOUT_CYCLES(TMO)) dut (
        .CLK   (clk),
        .RESET (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [N-1:0] req;
    logic [27:0]  addr_m [N];
    logic [127:0] rd_m [N];
    logic [N-1:0] err_m;
    int           order[$];
    int           mem_lat;
    int           mem_cnt;
    int           n_assert;
    int           n_fail;

    function automatic logic [127:0] block(input logic [27:0] a);
        if (a == 28'h3) return {16{8'hA5}};
        return {a, 4'h1, ~a, 4'h2, a ^ 28'h5A5A5A5, 4'h3, a[13:0], a[27:14], 4'h4};
    endfunction

    assign bus.REQ_READ = req;
    always_comb begin
        bus.REQ_ADDRESS = '0;
        for (int i = 0; i < N; i++) bus.REQ_ADDRESS[i*28 +: 28] = addr_m[i];
    end

    // Memory: busy for mem_lat WAIT samples after the issue cycle, data is a fixed function of address.
    always @(posedge clk) mem_cnt <= bus.MEM_READ ? mem_cnt + 1 : 0;
    assign bus.MEM_BUSYWAIT = bus.MEM_READ && (mem_cnt <= mem_lat);
    assign bus.MEM_READDATA = block(bus.MEM_ADDRESS);

    task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [511:0] rd_cat();
        logic [511:0] r;
        r = '0;
        for (int i = 0; i < N; i++) r[i*128 +: 128] = rd_m[i];
        return r;
    endfunction

    function automatic int model_pick();
        int g;
        g = -1;
        for (int i = N - 1; i >= 0; i--) if (req[order[i]]) g = order[i];
        return g;
    endfunction

    task automatic model_served(input int g);
        while (order[N-1] != g) order.push_back(order.pop_front());
    endtask

    task automatic model_reset();
        order.delete();
        for (int i = 0; i < N; i++) begin
            order.push_back(i);
            rd_m[i] = '0;
        end
        err_m = '0;
    endtask

    task automatic serve(input int g, input bit rel, input bit drop_mid, input bit tmo);
        int           n;
        int           hi;
        logic [27:0]  a;
        logic [N-1:0] bw_exp;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.MEM_READ !== 1'b1 && n < 50);
        chk("grant_latency", 512'(n), 512'(1));
        chk("mem_address", 512'(bus.MEM_ADDRESS), 512'(addr_m[g]));
        a  = addr_m[g];
        hi = 1;
        while (hi < 300) begin
            if (hi == 2) begin
                addr_m[g] = 28'($urandom);
                if (drop_mid) req[g] = 1'b0;
            end
            @(negedge clk);
            if (bus.MEM_READ !== 1'b1) break;
            hi++;
            chk("busywait_in_flight", 512'(bus.REQ_BUSYWAIT), 512'(req));
        end
        chk("read_cycles", 512'(hi), tmo ? 512'(TMO + 1) : 512'(mem_lat + 2));
        rd_m[g] = tmo ? 128'h0 : block(a);
        if (tmo) err_m[g] = 1'b1;
        bw_exp    = req;
        bw_exp[g] = 1'b0;
        chk("done_busywait", 512'(bus.REQ_BUSYWAIT), 512'(bw_exp));
        chk("readdata", bus.REQ_READDATA, rd_cat());
        chk("error", 512'(bus.ERROR), 512'(err_m));
        model_served(g);
        if (rel) req[g] = 1'b0;
        @(negedge clk);
        chk("idle_gap", 512'(bus.MEM_READ), 512'(0));
        chk("idle_busywait", 512'(bus.REQ_BUSYWAIT), 512'(req));
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        req      = '0;
        mem_lat  = 0;
        rst      = 1'b1;
        for (int i = 0; i < N; i++) addr_m[i] = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk("rst_mem_read", 512'(bus.MEM_READ), 512'(0));
        chk("rst_mem_address", 512'(bus.MEM_ADDRESS), 512'(0));
        chk("rst_readdata", bus.REQ_READDATA, 512'(0));
        chk("rst_busywait", 512'(bus.REQ_BUSYWAIT), 512'(0));
        chk("rst_error", 512'(bus.ERROR), 512'(0));
        rst = 1'b0;

        // All four at once: strict order 0,1,2,3 out of reset.
        for (int i = 0; i < N; i++) addr_m[i] = 28'(i);
        req     = '1;
        mem_lat = 2;
        for (int i = 0; i < N; i++) serve(i, 1'b1, 1'b0, 1'b0);

        // Requester 1 holds its request alongside 0 and 3.
        req = 4'b1011;
        mem_lat = 1;
        serve(0, 1'b0, 1'b0, 1'b0);
        serve(1, 1'b0, 1'b0, 1'b0);
        serve(3, 1'b0, 1'b0, 1'b0);
        serve(0, 1'b1, 1'b0, 1'b0);
        serve(1, 1'b1, 1'b0, 1'b0);
        serve(3, 1'b1, 1'b0, 1'b0);

        // Single request from requester 2 at block 3, five busy cycles.
        addr_m[2] = 28'h0000003;
        req[2]    = 1'b1;
        mem_lat   = 5;
        serve(2, 1'b1, 1'b0, 1'b0);

        // Requester 0 withdraws during WAIT; requester 2 is next.
        addr_m[0] = 28'h0ABCDEF;
        addr_m[2] = 28'h0123456;
        req       = 4'b0101;
        mem_lat   = 3;
        serve(0, 1'b1, 1'b1, 1'b0);
        serve(2, 1'b1, 1'b0, 1'b0);

        // Reset in WAIT abandons the read and restores requester 0 as first choice.
        addr_m[0] = 28'h0000100;
        addr_m[3] = 28'h0000300;
        req       = 4'b1001;
        mem_lat   = 6;
        @(negedge clk);
        chk("pre_reset_read", 512'(bus.MEM_READ), 512'(1));
        chk("pre_reset_addr", 512'(bus.MEM_ADDRESS), 512'(28'h0000300));
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("reset_wait_read", 512'(bus.MEM_READ), 512'(0));
        chk("reset_wait_data", bus.REQ_READDATA, 512'(0));
        chk("reset_wait_busywait", 512'(bus.REQ_BUSYWAIT), 512'(req));
        rst = 1'b0;
        model_reset();
        serve(0, 1'b1, 1'b0, 1'b0);
        serve(3, 1'b1, 1'b0, 1'b0);

        // Random request mixes against the reference model.
        for (int r = 0; r < 30; r++) begin
            for (int i = 0; i < N; i++) begin
                if (!req[i] && $urandom_range(0, 1) == 1) begin
                    req[i]    = 1'b1;
                    addr_m[i] = 28'($urandom);
                end
            end
            if (req == '0) req[$urandom_range(0, N - 1)] = 1'b1;
            mem_lat = $urandom_range(0, 6);
            serve(model_pick(), $urandom_range(0, 2) != 0, $urandom_range(0, 3) == 0, 1'b0);
        end
        for (int k = 0; k < N && req != '0; k++) serve(model_pick(), 1'b1, 1'b0, 1'b0);

`ifdef ARB_TIMEOUT_EN
        addr_m[1] = 28'h0000077;
        req[1]    = 1'b1;
        mem_lat   = 100000;
        serve(model_pick(), 1'b1, 1'b0, 1'b1);
        addr_m[2] = 28'h0000055;
        req[2]    = 1'b1;
        mem_lat   = 1;
        serve(model_pick(), 1'b1, 1'b0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
`endif
        chk("final_error", 512'(bus.ERROR), 512'(err_m));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
